// File: rtl/cam_event_queue_if.sv
// Event-in / word-out bundle between a bus snooper, the event queue and the nibble serializer.
// Latency: none, wires only.
// Backpressure: events are never stalled; words are gated by busy_i on the serializer side.
//
// Signals:
//   ev_valid_i/ev_type_i/ev_addr_i/ev_data_i : one-cycle event capture
//   busy_i, wr_o, data_o                      : serializer handshake and packed word
//   level_o, overflow_o, drop_count_o         : occupancy and drop statistics
//   stat_clr_i                                : clears the drop statistics
// Modports: slave = queue side, master = driver/observer side.
interface cam_event_queue_if #(
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic          ev_valid_i;
  logic [1:0]    ev_type_i;
  logic [15:0]   ev_addr_i;
  logic [7:0]    ev_data_i;
  logic          busy_i;
  logic          stat_clr_i;
  logic          wr_o;
  logic [31:0]   data_o;
  logic [AW:0]   level_o;
  logic          overflow_o;
  logic [7:0]    drop_count_o;

  modport slave (
    input  ev_valid_i, ev_type_i, ev_addr_i, ev_data_i, busy_i, stat_clr_i,
    output wr_o, data_o, level_o, overflow_o, drop_count_o
  );

  modport master (
    output ev_valid_i, ev_type_i, ev_addr_i, ev_data_i, busy_i, stat_clr_i,
    input  wr_o, data_o, level_o, overflow_o, drop_count_o
  );
endinterface

// File: rtl/cam_event_queue.sv
// Buffers unstallable bus events and launches packed 32-bit words to the camera-port serializer.
// Latency: 2 clocks from ev_valid_i to wr_o when empty, idle and not busy; wr_o pulses spaced >= 3 clocks.
// Backpressure: none upstream (a push into a full FIFO is dropped and counted); words wait while busy_i is high.
//
// Ports:
//   clk_i, rst_n : clock, asynchronous active-low reset
//   bus (slave)  : event inputs, serializer handshake (busy_i/wr_o/data_o),
//                  level_o occupancy, overflow_o/drop_count_o statistics, stat_clr_i
// Word layout: {type[1:0], seq[5:0], addr[15:0], data[7:0]}.
// Optional feature macro: CAM_HEARTBEAT_EN -- after HB_CYCLES idle clocks a
// heartbeat word {2'b11, seq, 16'hFFFF, drop_count} is launched.
module cam_event_queue #(
  parameter int DEPTH     = 16,
  parameter int HB_CYCLES = 2**20
) (
  input  logic             clk_i,
  input  logic             rst_n,
  cam_event_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [5:0]    r_seq;
  logic          r_wr;
  logic          w_wr_nxt;
  logic [31:0]   r_data;
  logic [31:0]   w_data_nxt;
  logic          r_ovf;
  logic [7:0]    r_drop;

  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_hb;
  logic [31:0]   w_ev_word;
  logic [31:0]   w_hb_word;

  // Fullness is judged on the registered level, so a same-cycle pop never
  // makes room for a push.
  assign w_full    = (r_level == FULL_LVL);
  assign w_push    = bus.ev_valid_i && !w_full;
  assign w_drop    = bus.ev_valid_i && w_full;
  assign w_ev_word = {bus.ev_type_i, r_seq, bus.ev_addr_i, bus.ev_data_i};

`ifdef CAM_HEARTBEAT_EN
  localparam int HBW = $clog2(HB_CYCLES) + 1;
  localparam logic [HBW-1:0] HB_LAST = HBW'(HB_CYCLES - 1);

  logic [HBW-1:0] r_idle_cnt;
  logic           w_idle_empty;

  assign w_idle_empty = (r_state == ST_IDLE) && (r_level == '0);
  // A same-cycle event takes the slot; its push restarts the idle count.
  assign w_hb      = w_idle_empty && (r_idle_cnt == HB_LAST) &&
                     !bus.busy_i && !bus.ev_valid_i;
  assign w_hb_word = {2'b11, r_seq, 16'hFFFF, r_drop};

  // Saturates at HB_LAST while the serializer is busy so the heartbeat
  // fires as soon as busy_i drops.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (w_push || r_wr) begin
      r_idle_cnt <= '0;
    end else if (w_idle_empty && (r_idle_cnt != HB_LAST)) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  logic w_unused_hb;
  assign w_unused_hb = (HB_CYCLES == 0);
  assign w_hb        = 1'b0;
  assign w_hb_word   = '0;
`endif

  // Launch FSM: IDLE pops and loads, SEND is the single wr_o cycle, HOLD
  // covers the serializer's one-cycle busy latency.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = 1'b0;
    w_data_nxt  = r_data;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((r_level != '0) && !bus.busy_i) begin
          w_pop       = 1'b1;
          w_data_nxt  = r_mem[r_rptr];
          w_wr_nxt    = 1'b1;
          w_state_nxt = ST_SEND;
        end else if (w_hb) begin
          w_data_nxt  = w_hb_word;
          w_wr_nxt    = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: w_state_nxt = ST_HOLD;
      ST_HOLD: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_wr    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wr    <= w_wr_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Storage needs no reset: only entries below the level are ever read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_ev_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // seq advances on every event, kept or dropped, so receivers see gaps.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_seq <= '0;
    end else if (bus.ev_valid_i || w_hb) begin
      r_seq <= r_seq + 1'b1;
    end
  end

  // Clear wins over a same-cycle drop.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (bus.stat_clr_i) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
    end
  end

  assign bus.wr_o         = r_wr;
  assign bus.data_o       = r_data;
  assign bus.level_o      = r_level;
  assign bus.overflow_o   = r_ovf;
  assign bus.drop_count_o = r_drop;
endmodule
